pipe_forward_unit: RTL and testbench

//  Parametrised forwarding/hazard unit; successor to the fixed 4-way ID forwarding mux.

---
 rtl/pipe_forward_unit.sv | 99 +++++++++
 tb/tb_pipe_forward_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_forward_unit.sv
// Purpose: ID-stage forwarding/hazard unit. It tracks in-flight destinations, selects forwarded operands and detects load-use stalls.
// Latency: all outputs are combinational from the scoreboard and the current ID inputs (0 cycles).
// Backpressure: raises stall for one cycle on a load-use hazard, and raises bubble on stall or flush. The scoreboard itself never holds.
// Optional feature: define STALL_COUNT_EN to build the saturating 16-bit stall-cycle counter.
module pipe_forward_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic                       id_rf_le,
  input  logic                       id_load,
  input  logic [REG_W-1:0]           id_rd,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic                       flush,
  input  logic [NUM_SRC*DATA_W-1:0]  rf_data,
  input  logic [DEPTH*DATA_W-1:0]    stg_data,
  output logic [NUM_SRC*SEL_W-1:0]   fw_sel,
  output logic [NUM_SRC*DATA_W-1:0]  fw_data,
  output logic                       stall,
  output logic                       bubble,
  output logic [15:0]                stall_cnt
);

  // Scoreboard: entry 0 is EX, entry DEPTH-1 is WB
  logic [DEPTH-1:0] sb_v;
  logic [DEPTH-1:0] sb_ld;
  logic [REG_W-1:0] sb_rd [DEPTH];

  // A stalled or flushed ID instruction enters as an invalid entry (bubble)
  logic ins_v;
  assign ins_v = id_valid & id_rf_le & ~stall & ~flush;

  // Shift the scoreboard every cycle; the WB entry falls off the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v  <= '0;
      sb_ld <= '0;
      for (int k = 0; k < DEPTH; k++) sb_rd[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_v[k]  <= sb_v[k-1];
        sb_ld[k] <= sb_ld[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      sb_v[0]  <= ins_v;
      sb_ld[0] <= id_load;
      sb_rd[0] <= id_rd;
    end
  end

  // Per-port forward select/data. The loop scans oldest to nearest, so the nearest match wins.
  // r0 never forwards.
  logic [NUM_SRC-1:0] ld_hit;
  always_comb begin
    fw_sel  = '0;
    fw_data = rf_data;
    ld_hit  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (sb_v[k] && (sb_rd[k] == id_src[i*REG_W +: REG_W]) &&
            (id_src[i*REG_W +: REG_W] != '0)) begin
          fw_sel[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
          fw_data[i*DATA_W +: DATA_W] = stg_data[k*DATA_W +: DATA_W];
        end
      end
      if (sb_v[0] && sb_ld[0] && (sb_rd[0] == id_src[i*REG_W +: REG_W]) &&
          (id_src[i*REG_W +: REG_W] != '0)) begin
        ld_hit[i] = 1'b1;
      end
    end
  end

  // A load in EX feeding ID costs one cycle. Flush takes priority over stall.
  assign stall  = id_valid & ~flush & (|ld_hit);
  assign bubble = stall | flush;

`ifdef STALL_COUNT_EN
  logic [15:0] cnt_q;

  // Count stall cycles, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_forward_unit.sv
// Bench for pipe_forward_unit: directed scenarios with literal checks, plus a per-cycle
// comparison against a history-based reference model of in-flight writers.
module tb_pipe_forward_unit;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int SEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      id_valid = 1'b0;
  logic                      id_rf_le = 1'b0;
  logic                      id_load = 1'b0;
  logic [REG_W-1:0]          id_rd = '0;
  logic [NUM_SRC*REG_W-1:0]  id_src = '0;
  logic                      flush = 1'b0;
  logic [NUM_SRC*DATA_W-1:0] rf_data = '0;
  logic [DEPTH*DATA_W-1:0]   stg_data = '0;
  logic [NUM_SRC*SEL_W-1:0]  fw_sel;
  logic [NUM_SRC*DATA_W-1:0] fw_data;
  logic                      stall;
  logic                      bubble;
  logic [15:0]               stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_forward_unit #(
    .DATA_W(DATA_W), .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rf_le(id_rf_le),
    .id_load(id_load), .id_rd(id_rd), .id_src(id_src), .flush(flush),
    .rf_data(rf_data), .stg_data(stg_data), .fw_sel(fw_sel), .fw_data(fw_data),
    .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of the last DEPTH issued instructions, nearest first
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } wr_t;
  wr_t hist [DEPTH];
  initial for (int k = 0; k < DEPTH; k++) hist[k] = '0;
  int  m_cnt = 0;

  function automatic int m_sel(input logic [REG_W-1:0] src);
    int s;
    s = 0;
    if (src != 0)
      for (int k = 0; k < DEPTH; k++)
        if (s == 0 && hist[k].v && hist[k].rd == src) s = k + 1;
    return s;
  endfunction

  function automatic logic m_stall();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (m_sel(id_src[i*REG_W +: REG_W]) == 1 && hist[0].ld) hit = 1'b1;
    return id_valid & ~flush & hit;
  endfunction

  // Advance the model history on the clock and clear it on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) hist[k] = '0;
      m_cnt = 0;
    end else begin
      logic st;
      st = m_stall();
      if (st && m_cnt < 65535) m_cnt++;
      for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0].v  = id_valid & id_rf_le & ~st & ~flush;
      hist[0].rd = id_rd;
      hist[0].ld = id_load;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    int s;
    logic [DATA_W-1:0] d;
    logic st;
    st = m_stall();
    for (int i = 0; i < NUM_SRC; i++) begin
      s = m_sel(id_src[i*REG_W +: REG_W]);
      d = (s == 0) ? rf_data[i*DATA_W +: DATA_W] : stg_data[(s-1)*DATA_W +: DATA_W];
      chk($sformatf("model fw_sel%0d", i), 64'(fw_sel[i*SEL_W +: SEL_W]), 64'(s));
      chk($sformatf("model fw_data%0d", i), 64'(fw_data[i*DATA_W +: DATA_W]), 64'(d));
    end
    chk("model stall", 64'(stall), 64'(st));
    chk("model bubble", 64'(bubble), 64'(st | flush));
`ifdef STALL_COUNT_EN
    chk("model stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`else
    chk("model stall_cnt", 64'(stall_cnt), 64'd0);
`endif
  end

  // Apply one ID instruction after the rising edge, then wait for the falling edge
  task automatic drive(input logic v, input logic le, input logic ld, input logic [4:0] rd,
                       input logic [4:0] s0, input logic [4:0] s1, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rf_le = le; id_load = ld; id_rd = rd;
    id_src = {s1, s0}; flush = fl;
    rf_data  = {$urandom, $urandom};
    stg_data = {$urandom, $urandom, $urandom};
    @(negedge clk);
  endtask

  logic [15:0] exp_cnt3;

  initial begin
`ifdef STALL_COUNT_EN
    exp_cnt3 = 16'd3;
`else
    exp_cnt3 = 16'd0;
`endif
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset fw_sel", 64'(fw_sel), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset fw_data", 64'(fw_data[31:0]), 64'(rf_data[31:0]));
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);

    // ALU writer r5 forwarded from EX
    drive(1, 1, 0, 5, 0, 0, 0);
    drive(1, 0, 0, 0, 5, 0, 0);
    chk("ex fwd sel0", 64'(fw_sel[1:0]), 64'd1);
    chk("ex fwd data0", 64'(fw_data[31:0]), 64'(stg_data[31:0]));

    // Three writers of r5: EX wins, then MEM, then WB
    repeat (3) drive(1, 1, 0, 5, 0, 0, 0);
    drive(1, 0, 0, 0, 5, 0, 0);
    chk("nearest ex", 64'(fw_sel[1:0]), 64'd1);
    drive(1, 0, 0, 0, 5, 0, 0);
    chk("nearest mem", 64'(fw_sel[1:0]), 64'd2);
    chk("mem data", 64'(fw_data[31:0]), 64'(stg_data[63:32]));
    drive(1, 0, 0, 0, 5, 0, 0);
    chk("wb only", 64'(fw_sel[1:0]), 64'd3);
    chk("wb data", 64'(fw_data[31:0]), 64'(stg_data[95:64]));
    drive(0, 0, 0, 0, 5, 0, 0);
    chk("drained sel", 64'(fw_sel[1:0]), 64'd0);

    // Load r7 then a consumer on port 1: one stall, then forward from MEM
    drive(1, 1, 1, 7, 0, 0, 0);
    drive(1, 1, 0, 8, 0, 7, 0);
    chk("load-use stall", 64'(stall), 64'd1);
    chk("load-use bubble", 64'(bubble), 64'd1);
    chk("load-use sel1 ex", 64'(fw_sel[3:2]), 64'd1);
    drive(1, 1, 0, 8, 0, 7, 0);
    chk("after stall", 64'(stall), 64'd0);
    chk("after stall sel1", 64'(fw_sel[3:2]), 64'd2);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Both ports on the same load: a single stall cycle
    drive(1, 1, 1, 7, 0, 0, 0);
    drive(1, 0, 0, 0, 7, 7, 0);
    chk("dual stall", 64'(stall), 64'd1);
    drive(1, 0, 0, 0, 7, 7, 0);
    chk("dual released", 64'(stall), 64'd0);
    chk("dual sel", 64'(fw_sel), 64'hA);

    // r0 writer (even a load) never forwards or stalls
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("r0 sel", 64'(fw_sel), 64'd0);
    chk("r0 data", 64'(fw_data[31:0]), 64'(rf_data[31:0]));
    chk("r0 stall", 64'(stall), 64'd0);

    // Flush beats stall and inserts no entry
    drive(1, 1, 1, 9, 0, 0, 0);
    drive(1, 1, 0, 10, 9, 0, 1);
    chk("flush stall", 64'(stall), 64'd0);
    chk("flush bubble", 64'(bubble), 64'd1);
    drive(1, 0, 0, 0, 9, 10, 0);
    chk("flush load in mem", 64'(fw_sel[1:0]), 64'd2);
    chk("flushed not inserted", 64'(fw_sel[3:2]), 64'd0);

    // Third load-use pair, then async reset during a stall
    drive(1, 1, 1, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 3, 0, 0);
    chk("third stall", 64'(stall), 64'd1);
    drive(1, 0, 0, 0, 3, 0, 0);
    chk("stall_cnt 3", 64'(stall_cnt), 64'(exp_cnt3));
    drive(1, 1, 1, 4, 0, 0, 0);
    drive(1, 0, 0, 0, 4, 0, 0);
    chk("pre-reset stall", 64'(stall), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async stall", 64'(stall), 64'd0);
    chk("async sel", 64'(fw_sel), 64'd0);
    chk("async data", 64'(fw_data), 64'(rf_data));
    chk("async stall_cnt", 64'(stall_cnt), 64'd0);
    #1 rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
